// File: rtl/alion_mem_arb_pkg.sv
// alion_mem_arb_pkg: FSM and grant types plus the all-ones timeout data pattern for alion_mem_arbiter
package alion_mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, MEM, RESP} state_e;
  typedef enum logic {GNT_I, GNT_D} gnt_e;
  localparam int MAX_DATA_W = 1024;
  function automatic logic [MAX_DATA_W-1:0] timeout_data(input int w);
    timeout_data = '0;
    for (int i = 0; i < w; i++) timeout_data[i] = 1'b1;
  endfunction
endpackage

// File: rtl/alion_mem_arb_timer.sv
// alion_mem_arb_timer: per-transaction watchdog, expired_o is high while the count sits at TIMEOUT-1
//   clk, reset : clock, synchronous active-high reset
//   load_i     : clear the count for a new transaction
//   en_i       : count one cycle spent waiting on memory
//   expired_o  : combinational, count == TIMEOUT-1
module alion_mem_arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] cnt_q;
  assign expired_o = cnt_q == W'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (reset || load_i) cnt_q <= '0;
    else if (en_i && !expired_o) cnt_q <= cnt_q + 1'b1;
endmodule

// File: rtl/alion_mem_arbiter.sv
// alion_mem_arbiter: shares one memory port between fetch (i_*) and data (d_*) requesters with a timeout watchdog
//   i_valid/i_addr -> i_ready/i_rdata       : fetch requester, ready is a one-cycle completion pulse
//   d_valid/d_addr/d_wdata/d_wstrb -> d_ready/d_rdata : data requester, wstrb==0 means load
//   mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb, mem_ready/mem_rdata : shared memory port
//   err_timeout : pulses with ready when memory never answered; busy : registered state != IDLE
//   ALION_MEM_ARB_RR_EN : alternate grants on contention instead of data-first priority
module alion_mem_arbiter
  import alion_mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_valid,
  output logic                mem_instr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_timeout,
  output logic                busy
);
  localparam logic [DATA_W-1:0] TO_DATA = DATA_W'(timeout_data(DATA_W));
  state_e              state_q, state_d;
  gnt_e                gnt_q, gnt_d, pick;
  logic                err_q, err_d, busy_q, load, expired;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d, rdata;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  alion_mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .reset(reset), .load_i(load), .en_i(state_q == MEM), .expired_o(expired)
  );
`ifdef ALION_MEM_ARB_RR_EN
  // gnt_q keeps the previous winner, so it doubles as the last-grant bit
  assign pick = (i_valid && d_valid) ? (gnt_q == GNT_D ? GNT_I : GNT_D) : (d_valid ? GNT_D : GNT_I);
`else
  assign pick = d_valid ? GNT_D : GNT_I;
`endif
  assign rdata = mem_ready ? mem_rdata : TO_DATA;
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    load      = 1'b0;
    case (state_q)
      IDLE: if (i_valid || d_valid) begin
        gnt_d   = pick;
        addr_d  = pick == GNT_D ? d_addr : i_addr;
        wdata_d = pick == GNT_D ? d_wdata : '0;
        wstrb_d = pick == GNT_D ? d_wstrb : '0;
        err_d   = 1'b0;
        load    = 1'b1;
        state_d = MEM;
      end
      MEM: if (mem_ready || expired) begin
        i_rdata_d = gnt_q == GNT_I ? rdata : i_rdata_q;
        d_rdata_d = gnt_q == GNT_D ? rdata : d_rdata_q;
        err_d     = !mem_ready;
        state_d   = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_D;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      err_q     <= err_d;
      busy_q    <= state_d != IDLE;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  assign mem_valid   = state_q == MEM;
  assign mem_instr   = gnt_q == GNT_I;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;
  assign i_ready     = state_q == RESP && gnt_q == GNT_I;
  assign d_ready     = state_q == RESP && gnt_q == GNT_D;
  assign err_timeout = state_q == RESP && err_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_alion_mem_arbiter.sv
// tb_alion_mem_arbiter: table-driven and randomized checks of alion_mem_arbiter against a transaction-level model
module tb_alion_mem_arbiter;
  localparam int TO = 4;
  logic        clk = 0, reset = 1;
  logic        i_valid = 0, d_valid = 0, mem_ready = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [3:0]  d_wstrb = 0;
  logic        i_ready, d_ready, mem_valid, mem_instr, err_timeout, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  int          checks = 0, errors = 0;
  logic [31:0] last_i = 0, last_d = 0;
  alion_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .err_timeout(err_timeout), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic iv, dv;
    logic [31:0] ia, da, dw;
    logic [3:0] ds;
    int wt;
    logic [31:0] rd;
    logic exp_d, exp_err;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl [6];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_i_ready"}, i_ready, 0);
    chk({tag, "_d_ready"}, d_ready, 0);
    chk({tag, "_err"}, err_timeout, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  // Called at a negedge with the request(s) already presented and the arbiter idle.
  // wt: MEM cycles the memory stalls before asserting mem_ready (>= TO means it never answers).
  task automatic serve(input logic exp_d, input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] es,
                       input int wt, input logic [31:0] rd, input logic exp_err, input logic [31:0] exp_rd);
    int n = 0;
    @(posedge clk);
    @(negedge clk);
    while (mem_valid && n < TO + 2) begin
      chk("mem_instr", mem_instr, !exp_d);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wstrb", mem_wstrb, exp_d ? es : 4'h0);
      if (exp_d) chk("mem_wdata", mem_wdata, ew);
      chk("mem_busy", busy, 1);
      chk("mem_no_ready", {i_ready, d_ready}, 0);
      mem_ready = n == wt;
      mem_rdata = n == wt ? rd : $urandom;
      n++;
      @(negedge clk);
    end
    mem_ready = 0;
    chk("mem_valid_cycles", n, wt >= TO ? TO : wt + 1);
    chk("resp_i_ready", i_ready, !exp_d);
    chk("resp_d_ready", d_ready, exp_d);
    chk("resp_err", err_timeout, exp_err);
    chk("resp_busy", busy, 1);
    if (exp_d) last_d = exp_rd; else last_i = exp_rd;
    chk("resp_i_rdata", i_rdata, last_i);
    chk("resp_d_rdata", d_rdata, last_d);
    if (exp_d) d_valid = 0; else i_valid = 0;
    @(negedge clk);
    chk_idle_outputs("post");
    chk("hold_i_rdata", i_rdata, last_i);
    chk("hold_d_rdata", d_rdata, last_d);
  endtask
  initial begin
    tbl[0] = '{1, 0, 32'h100, 0, 0, 4'h0, 0, 32'h0000_0013, 0, 0, 32'h0000_0013};
    tbl[1] = '{0, 1, 0, 32'h200, 32'hA5A5_1234, 4'b0011, 3, 32'h7777_0000, 1, 0, 32'h7777_0000};
    tbl[2] = '{0, 1, 0, 32'h300, 32'h1, 4'h0, 7, 32'h1234_5678, 1, 1, 32'hFFFF_FFFF};
    tbl[3] = '{1, 0, 32'h404, 0, 0, 4'h0, 9, 32'h0, 0, 1, 32'hFFFF_FFFF};
    tbl[4] = '{1, 1, 32'h500, 32'h600, 32'hCAFE_F00D, 4'hF, 1, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF};
    tbl[5] = '{0, 1, 0, 32'h704, 32'h0, 4'h0, 2, 32'h0BAD_CAFE, 1, 0, 32'h0BAD_CAFE};
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_rdata", {i_rdata, d_rdata}, 0);
    chk("reset_mem_fields", {mem_instr, mem_addr, mem_wdata, mem_wstrb}, 0);
    reset = 0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      i_valid = tbl[k].iv; i_addr = tbl[k].ia;
      d_valid = tbl[k].dv; d_addr = tbl[k].da; d_wdata = tbl[k].dw; d_wstrb = tbl[k].ds;
      serve(tbl[k].exp_d, tbl[k].exp_d ? tbl[k].da : tbl[k].ia, tbl[k].dw, tbl[k].ds,
            tbl[k].wt, tbl[k].rd, tbl[k].exp_err, tbl[k].exp_rd);
      if (tbl[k].iv && tbl[k].dv)
        serve(0, tbl[k].ia, 0, 0, 1, ~tbl[k].rd, 0, ~tbl[k].rd);
    end
    // reset while a fetch is in MEM: dropped silently, everything back to zero
    i_valid = 1; i_addr = 32'h900;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_mem_valid", mem_valid, 1);
    reset = 1; i_valid = 0;
    @(negedge clk);
    reset = 0;
    chk_idle_outputs("rst_mid");
    chk("rst_mid_fields", {mem_instr, mem_addr, mem_wdata, mem_wstrb, i_rdata, d_rdata}, 0);
    last_i = 0; last_d = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_pulse", {i_ready, d_ready, err_timeout, busy}, 0);
    end
    i_valid = 1; i_addr = 32'hA00;
    serve(0, 32'hA00, 0, 0, 0, 32'h1357_9BDF, 0, 32'h1357_9BDF);
    // randomized transactions against the transaction-level model
    for (int k = 0; k < 40; k++) begin
      logic iv, dv, wd, e;
      logic [31:0] rd;
      int wt;
      iv = 1'($urandom); dv = 1'($urandom);
      if (!iv && !dv) iv = 1;
      i_valid = iv; i_addr = $urandom; d_valid = dv; d_addr = $urandom;
      d_wdata = $urandom; d_wstrb = 4'($urandom);
      wt = $urandom_range(0, TO + 1); rd = $urandom;
      wd = dv;
      e = wt >= TO;
      serve(wd, wd ? d_addr : i_addr, d_wdata, d_wstrb, wt, rd, e, e ? 32'hFFFF_FFFF : rd);
      if (iv && dv) begin
        wt = $urandom_range(0, TO + 1); rd = $urandom;
        e = wt >= TO;
        serve(0, i_addr, 0, 0, wt, rd, e, e ? 32'hFFFF_FFFF : rd);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
